touch_i2c_target: RTL

TOUCH_I2C_TARGET -- requirements
Module: touch_i2c_target

---
 rtl/touch_i2c_target.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/touch_i2c_target.sv
// I2C target exposing the latest touch sample (status, event, x, y) as a
// read-only register file with coherent multi-byte reads and an interrupt.
module touch_i2c_target #(
    parameter logic [6:0] I2C_ADDR    = 7'h38,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe_out,
    output logic        irq_n_out,
    input  logic        valid_in,
    input  logic        lift_in,
    input  logic [11:0] x_in,
    input  logic [11:0] y_in
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RD_ACK, IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_reg;
    logic [SYNC_STAGES-1:0] sda_sync_reg;
    logic scl_prev_reg, sda_prev_reg;
    logic scl_s, sda_s;
    logic scl_rise, scl_fall, start_det, stop_det;

    state_t      state_reg, state_next;
    logic [2:0]  bit_cnt_reg, bit_cnt_next;
    logic [7:0]  shift_reg, shift_next, shift_in;
    logic [7:0]  ptr_reg, ptr_next;
    logic        rw_reg, rw_next;
    logic [7:0]  tx_reg, tx_next;
    logic        sda_oe_reg, sda_oe_next;
    logic        snap, rd_clr;
    logic [7:0]  rd_byte;

    logic        status_reg, shd_status_reg;
    logic [1:0]  event_reg, shd_event_reg;
    logic [11:0] x_reg, y_reg, shd_x_reg, shd_y_reg;
    logic        pending_reg, dirty_reg;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk_in or negedge rst_in) begin
                    if (!rst_in) begin
                        scl_sync_reg[gi] <= 1'b1;
                        sda_sync_reg[gi] <= 1'b1;
                    end else begin
                        scl_sync_reg[gi] <= scl_in;
                        sda_sync_reg[gi] <= sda_in;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk_in or negedge rst_in) begin
                    if (!rst_in) begin
                        scl_sync_reg[gi] <= 1'b1;
                        sda_sync_reg[gi] <= 1'b1;
                    end else begin
                        scl_sync_reg[gi] <= scl_sync_reg[gi-1];
                        sda_sync_reg[gi] <= sda_sync_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign scl_s     = scl_sync_reg[SYNC_STAGES-1];
    assign sda_s     = sda_sync_reg[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_reg;
    assign scl_fall  = ~scl_s & scl_prev_reg;
    // SCL must be high on both samples so an SCL edge coinciding with an SDA edge is never a START/STOP
    assign start_det = scl_s & scl_prev_reg & sda_prev_reg & ~sda_s;
    assign stop_det  = scl_s & scl_prev_reg & ~sda_prev_reg & sda_s;
    assign shift_in  = {shift_reg[6:0], sda_s};

    always_comb begin
        rd_byte = 8'h00;
        case (ptr_reg)
            8'h02:   rd_byte = {7'b0, shd_status_reg};
            8'h03:   rd_byte = {shd_event_reg, 2'b00, shd_x_reg[11:8]};
            8'h04:   rd_byte = shd_x_reg[7:0];
            8'h05:   rd_byte = {shd_event_reg, 2'b00, shd_y_reg[11:8]};
            8'h06:   rd_byte = shd_y_reg[7:0];
            default: rd_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        ptr_next     = ptr_reg;
        rw_next      = rw_reg;
        tx_next      = tx_reg;
        sda_oe_next  = sda_oe_reg;
        snap         = 1'b0;
        rd_clr       = 1'b0;
        if (stop_det) begin
            state_next = IDLE;
        end else if (start_det) begin
            state_next   = ADDR;
            bit_cnt_next = 3'd0;
        end else if (scl_rise) begin
            case (state_reg)
                ADDR, PTR, WDATA: begin
                    shift_next   = shift_in;
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        if (state_reg == ADDR) begin
                            if (shift_in[7:1] == I2C_ADDR) begin
                                state_next = ADDR_ACK;
                                rw_next    = shift_in[0];
                                snap       = shift_in[0];
                            end else begin
                                state_next = IGNORE;
                            end
                        end else if (state_reg == PTR) begin
                            ptr_next   = shift_in;
                            state_next = PTR_ACK;
                        end else begin
                            ptr_next   = ptr_reg + 8'd1;
                            state_next = WDATA_ACK;
                        end
                    end
                end
                ADDR_ACK: begin
                    state_next = rw_reg ? RDATA : PTR;
                    tx_next    = rd_byte;
                end
                PTR_ACK, WDATA_ACK: state_next = WDATA;
                RDATA: begin
                    tx_next      = {tx_reg[6:0], 1'b0};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        ptr_next   = ptr_reg + 8'd1;
                        rd_clr     = (ptr_reg == 8'h06);
                        state_next = RD_ACK;
                    end
                end
                RD_ACK: begin
                    if (!sda_s) begin
                        state_next = RDATA;
                        tx_next    = rd_byte;
                    end else begin
                        state_next = IGNORE;
                    end
                end
                default: state_next = state_reg;
            endcase
        end else if (scl_fall) begin
            case (state_reg)
                ADDR_ACK, PTR_ACK, WDATA_ACK: sda_oe_next = 1'b1;
                RDATA:                        sda_oe_next = ~tx_reg[7];
                default:                      sda_oe_next = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            scl_prev_reg <= 1'b1;
            sda_prev_reg <= 1'b1;
            state_reg    <= IDLE;
            bit_cnt_reg  <= 3'd0;
            shift_reg    <= 8'h00;
            ptr_reg      <= 8'h00;
            rw_reg       <= 1'b0;
            tx_reg       <= 8'h00;
            sda_oe_reg   <= 1'b0;
        end else begin
            scl_prev_reg <= scl_s;
            sda_prev_reg <= sda_s;
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            ptr_reg      <= ptr_next;
            rw_reg       <= rw_next;
            tx_reg       <= tx_next;
            sda_oe_reg   <= sda_oe_next;
        end
    end

    // dirty marks a touch event newer than the snapshot, so a read cannot clear its interrupt
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            status_reg     <= 1'b0;
            event_reg      <= 2'b00;
            x_reg          <= 12'h000;
            y_reg          <= 12'h000;
            shd_status_reg <= 1'b0;
            shd_event_reg  <= 2'b00;
            shd_x_reg      <= 12'h000;
            shd_y_reg      <= 12'h000;
            pending_reg    <= 1'b0;
            dirty_reg      <= 1'b0;
        end else begin
            if (valid_in) begin
                x_reg      <= x_in;
                y_reg      <= y_in;
                status_reg <= 1'b1;
                event_reg  <= 2'b00;
            end else if (lift_in) begin
                status_reg <= 1'b0;
                event_reg  <= 2'b01;
            end
            if (snap) begin
                shd_status_reg <= status_reg;
                shd_event_reg  <= event_reg;
                shd_x_reg      <= x_reg;
                shd_y_reg      <= y_reg;
            end
            if (valid_in || lift_in) begin
                pending_reg <= 1'b1;
                dirty_reg   <= 1'b1;
            end else begin
                if (rd_clr && !dirty_reg) pending_reg <= 1'b0;
                if (snap) dirty_reg <= 1'b0;
            end
        end
    end

    assign sda_oe_out = sda_oe_reg;
    assign irq_n_out  = ~pending_reg;

endmodule
